inta_sequencer: RTL

- CPU-side initiator of the 8259A interrupt-acknowledge protocol, sitting between the CPU core model and the priority resolver.
- Samples the PIC's INT output and, when interrupts are enabled, drives two active-low INTA pulses (8086 mode).
- Captures the vector byte from the data bus during the second pulse and hands it to the core over a valid/ready handshake.
- Guarantees pulse widths and inter-pulse gaps so the PIC can set ISR on the first pulse and drive the vector on the second.

---
 rtl/pic_pkg.sv | 25 ++
 rtl/inta_sequencer_if.sv | 36 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/inta_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared types and constants for the interrupt-controller slice: the
// interrupt-acknowledge sequencer and the priority resolver both import this.
//   inta_state_t     : acknowledge sequencer FSM states
//   INTA_PULSES_8086 : number of INTA pulses per acknowledge in 8086 mode
//   vector_t         : 8-bit interrupt vector byte
// ---------------------------------------------------------------------------
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      P1_LOW,
      GAP,
      P2_LOW,
      HOLD,
      RECOVER
   } inta_state_t;

   // 8086 mode: first pulse freezes priority and sets ISR, second reads vector
   localparam int INTA_PULSES_8086 = 2;

   typedef logic [7:0] vector_t;

endpackage

// File: rtl/inta_sequencer_if.sv
// ---------------------------------------------------------------------------
// inta_sequencer_if
// Bundles the PIC-facing and core-facing signals of the acknowledge sequencer.
//   INT       : interrupt request from the PIC (asynchronous)
//   int_en    : CPU interrupt-enable flag
//   D         : data bus from the PIC, vector valid during the second pulse
//   INTA_N    : active-low interrupt acknowledge to the PIC
//   vec       : captured vector
//   vec_valid : vec holds an unconsumed vector
//   vec_ready : core accepts vec on vec_valid && vec_ready
//   busy      : sequencer is not idle
// master = the sequencer, slave = the PIC/core environment.
// ---------------------------------------------------------------------------
interface inta_sequencer_if;
   import pic_pkg::*;

   logic    INT;
   logic    int_en;
   vector_t D;
   logic    INTA_N;
   vector_t vec;
   logic    vec_valid;
   logic    vec_ready;
   logic    busy;

   modport master (
      input  INT, int_en, D, vec_ready,
      output INTA_N, vec, vec_valid, busy
   );

   modport slave (
      output INT, int_en, D, vec_ready,
      input  INTA_N, vec, vec_valid, busy
   );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer for bringing asynchronous request lines
// (INT, IR inputs) into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk edges after d
// ---------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/inta_sequencer.sv
// ---------------------------------------------------------------------------
// inta_sequencer
// CPU-side initiator of the 8259A two-pulse (8086 mode) interrupt-acknowledge
// protocol. When the synchronized INT is seen with interrupts enabled it
// drives two INTA_N low pulses separated by a gap, captures the vector from D
// at the end of the second pulse, offers it to the core with a valid/ready
// handshake, then holds INTA_N high for a recovery period so the PIC can
// withdraw INT before it is looked at again.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : inta_sequencer_if master modport (INT, int_en, D, INTA_N, vec,
//           vec_valid, vec_ready, busy)
// Parameters:
//   PULSE_CYCLES : cycles INTA_N is low per pulse (>=1)
//   GAP_CYCLES   : cycles INTA_N is high between pulses and in recovery (>=1)
// ---------------------------------------------------------------------------
module inta_sequencer
   import pic_pkg::*;
#(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 2
) (
   input logic               clk,
   input logic               rst_n,
   inta_sequencer_if.master  bus
);

   localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   // Counter reload values: the counter runs load..0, so a value of N-1
   // keeps the state for exactly N cycles.
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   inta_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             int_s;
   logic             inta_n_r;
   logic             vec_valid_r;
   logic             busy_r;
   vector_t          vec_r;

   sync_2ff u_int_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.INT),
      .q     (int_s)
   );

   // Acknowledge sequencer. Every output is a register updated alongside the
   // state, so INTA_N can only change on a clock edge and never glitches.
   // Once P1_LOW is entered the sequence runs to completion regardless of
   // INT or int_en: the PIC has already committed to an acknowledge cycle
   // and will supply its spurious vector if the request vanished.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         inta_n_r    <= 1'b1;
         vec_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         vec_r       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (int_s && bus.int_en) begin
                  state    <= P1_LOW;
                  cnt      <= PULSE_LOAD;
                  inta_n_r <= 1'b0;
                  busy_r   <= 1'b1;
               end
            end

            P1_LOW: begin
               if (cnt == '0) begin
                  state    <= GAP;
                  cnt      <= GAP_LOAD;
                  inta_n_r <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            GAP: begin
               if (cnt == '0) begin
                  state    <= P2_LOW;
                  cnt      <= PULSE_LOAD;
                  inta_n_r <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            // The PIC drives D for the whole second pulse, so sampling at
            // the edge that ends it gives the most settling time.
            P2_LOW: begin
               if (cnt == '0) begin
                  state       <= HOLD;
                  cnt         <= '0;
                  inta_n_r    <= 1'b1;
                  vec_r       <= bus.D;
                  vec_valid_r <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            HOLD: begin
               if (bus.vec_ready) begin
                  state       <= RECOVER;
                  cnt         <= GAP_LOAD;
                  vec_valid_r <= 1'b0;
               end
            end

            RECOVER: begin
               if (cnt == '0) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_r <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            default: begin
               state       <= IDLE;
               cnt         <= '0;
               inta_n_r    <= 1'b1;
               vec_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.INTA_N    = inta_n_r;
   assign bus.vec       = vec_r;
   assign bus.vec_valid = vec_valid_r;
   assign bus.busy      = busy_r;

endmodule
